// File: rtl/apb_multi_master_bridge.sv
// APB master bridge with NUM_SLAVES-way address decode, wait states, PSLVERR,
// unmapped-address errors, transfer timeout and back-to-back command acceptance.
module apb_multi_master_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             done,
  output logic                             err,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       state,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY_s,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_s,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_s
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q, pend_d;

  logic [SEL_BITS-1:0]     req_idx;
  logic                    req_mapped;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic                    sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    accept, timeout_hit;

  // The latched one-hot PSEL doubles as the stored slave index for the return mux.
  always_comb begin
    req_idx    = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
    req_mapped = 32'(req_idx) < 32'(NUM_SLAVES);
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < 32'(NUM_SLAVES); i++) begin
      req_onehot[i] = (32'(req_idx) == i);
      sel_ready     = sel_ready | (psel_q[i] & PREADY_s[i]);
      sel_err       = sel_err | (psel_q[i] & PSLVERR_s[i]);
      if (psel_q[i]) sel_rdata = sel_rdata | PRDATA_s[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req_ready   = (state_q == IDLE) || ((state_q == ACCESS) && sel_ready);
  assign accept      = req && req_ready;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !sel_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && req_mapped) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (sel_ready)        state_d = (accept && req_mapped) ? SETUP : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d   = psel_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    pend_d   = 1'b0;

    if (accept && req_mapped) begin
      psel_d   = req_onehot;
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
    end

    unique case (state_q)
      // An unmapped command taken at a completion edge is reported one cycle
      // later via pend_q so its error pulse never merges with the first done.
      IDLE: begin
        if (pend_q) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
        if (accept && !req_mapped) begin
          if (pend_q) begin
            pend_d = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          done_d  = 1'b1;
          err_d   = sel_err;
          rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
          pend_d  = accept && !req_mapped;
        end else if (timeout_hit) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_d == IDLE) psel_d = '0;
    penable_d = (state_d == ACCESS);
    cnt_d     = ((state_q == ACCESS) && (state_d == ACCESS)) ? cnt_q + 1'b1 : '0;
  end

  assign state   = state_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_multi_master_bridge.sv
// Bench for apb_multi_master_bridge: directed vector table, hand-written
// multi-cycle sequences and random transactions against a transaction-level model.
module tb_apb_multi_master_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 16;
  localparam int BOUND = 40;

  logic          PCLK, PRESET;
  logic          req, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          done, err;
  logic [DW-1:0] rdata;
  logic [1:0]    state;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [NS-1:0] PREADY_s, PSLVERR_s;
  logic [NS*DW-1:0] PRDATA_s;

  int checks = 0;
  int errors = 0;

  apb_multi_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_BITS(2), .NUM_SLAVES(NS), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata), .state(state),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY_s(PREADY_s), .PSLVERR_s(PSLVERR_s), .PRDATA_s(PRDATA_s)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    bit          slverr;
    logic [31:0] prdata;
  } txn_t;

  typedef struct {
    txn_t        t;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_done;
    logic [2:0]  exp_psel;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Target slave gets the scripted response; everything else gets noise.
  task automatic drive_slaves(input int tgt, input bit rdy, input bit serr, input logic [31:0] rd);
    for (int s = 0; s < NS; s++) begin
      if (s == tgt) begin
        PREADY_s[s]          = rdy;
        PSLVERR_s[s]         = rdy ? serr : 1'($urandom);
        PRDATA_s[s*DW +: DW] = rdy ? rd : $urandom;
      end else begin
        PREADY_s[s]          = 1'($urandom);
        PSLVERR_s[s]         = 1'($urandom);
        PRDATA_s[s*DW +: DW] = $urandom;
      end
    end
  endtask

  function automatic vec_t mkvec(bit wr, logic [7:0] addr, logic [31:0] wd, int waits, bit serr,
                                 logic [31:0] prd, bit e_err, logic [31:0] e_rd, int e_done,
                                 logic [2:0] e_psel);
    vec_t v;
    v.t.wr = wr; v.t.addr = addr; v.t.wdata = wd; v.t.waits = waits;
    v.t.slverr = serr; v.t.prdata = prd;
    v.exp_err = e_err; v.exp_rdata = e_rd; v.exp_done = e_done; v.exp_psel = e_psel;
    return v;
  endfunction

  // Transaction-level reference: outcome from decode, wait count and timeout rule.
  function automatic vec_t model(txn_t t);
    vec_t v;
    int   idx;
    bit   mapped, tmo;
    idx    = int'(t.addr[7:6]);
    mapped = idx < NS;
    tmo    = mapped && (t.waits >= TO);
    v.t        = t;
    v.exp_err  = !mapped || tmo || t.slverr;
    v.exp_done = !mapped ? 1 : (tmo ? TO + 2 : t.waits + 3);
    v.exp_rdata = (!v.exp_err && !t.wr) ? t.prdata : 32'h0;
    v.exp_psel = mapped ? (3'b001 << idx) : 3'b000;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int idx;
    bit mapped, seen, rdy;
    idx    = int'(v.t.addr[7:6]);
    mapped = idx < NS;
    seen   = 1'b0;
    for (int c = 0; c < BOUND && !seen; c++) begin
      req       = (c == 0);
      req_write = v.t.wr;
      req_addr  = v.t.addr;
      req_wdata = v.t.wdata;
      rdy       = mapped && (c == 2 + v.t.waits);
      drive_slaves(mapped ? idx : -1, rdy, v.t.slverr, v.t.prdata);
      #1;
      if (c == 0) chk({tag, ".req_ready"}, req_ready, 1);
      if (c == 1) begin
        chk({tag, ".psel_c1"}, PSEL, v.exp_psel);
        chk({tag, ".penable_c1"}, PENABLE, 0);
        chk({tag, ".state_c1"}, state, mapped ? 1 : 0);
      end
      if (c == 2 && mapped) begin
        chk({tag, ".penable_c2"}, PENABLE, 1);
        chk({tag, ".paddr"}, PADDR, v.t.addr);
        chk({tag, ".pwrite"}, PWRITE, v.t.wr);
        if (v.t.wr) chk({tag, ".pwdata"}, PWDATA, v.t.wdata);
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, ".done_cycle"}, c, v.exp_done);
        chk({tag, ".err"}, err, v.exp_err);
        chk({tag, ".rdata"}, rdata, v.exp_rdata);
        chk({tag, ".idle_at_done"}, {state, PSEL, PENABLE}, 0);
      end
      step();
    end
    req = 1'b0;
    if (!seen) chk({tag, ".done_seen"}, 0, 1);
    else chk({tag, ".quiet_after_done"}, {done, err, rdata}, 0);
  endtask

  initial begin
    txn_t t;

    tbl[0] = mkvec(1, 8'h45, 32'hDEADBEEF, 0,   0, 32'h0,        0, 32'h0,        3,  3'b010);
    tbl[1] = mkvec(0, 8'h82, 32'h0,        3,   0, 32'h12345678, 0, 32'h12345678, 6,  3'b100);
    tbl[2] = mkvec(0, 8'hC0, 32'h0,        0,   0, 32'h0,        1, 32'h0,        1,  3'b000);
    tbl[3] = mkvec(0, 8'h10, 32'h0,        100, 0, 32'h0,        1, 32'h0,        18, 3'b001);
    tbl[4] = mkvec(0, 8'h04, 32'h0,        0,   1, 32'hAAAA5555, 1, 32'h0,        3,  3'b001);
    tbl[5] = mkvec(1, 8'h7F, 32'h0BADF00D, 15,  0, 32'h0,        0, 32'h0,        18, 3'b010);
    tbl[6] = mkvec(0, 8'h9C, 32'h0,        16,  0, 32'h55555555, 1, 32'h0,        18, 3'b100);
    tbl[7] = mkvec(0, 8'h3F, 32'h0,        2,   0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 5,  3'b001);

    PRESET = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    drive_slaves(-1, 0, 0, 0);
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset.state", state, 0);
    chk("reset.apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    chk("reset.out", {done, err, rdata}, 0);
    chk("reset.req_ready", req_ready, 1);
    PRESET = 1'b0;
    step();

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back mapped: write 0x01 (slave 0) then read 0x41 (slave 1).
    req = 1; req_write = 1; req_addr = 8'h01; req_wdata = 32'h11112222;
    drive_slaves(0, 0, 0, 0); #1;
    chk("b2b.ready_c0", req_ready, 1);
    step();
    req_write = 0; req_addr = 8'h41; drive_slaves(0, 0, 0, 0); #1;
    chk("b2b.ready_c1", req_ready, 0);
    step();
    drive_slaves(0, 1, 0, 0); #1;
    chk("b2b.ready_c2", req_ready, 1);
    step();
    chk("b2b.done1", {done, err}, 2'b10);
    chk("b2b.setup2", {state, PSEL, PENABLE}, {2'd1, 3'b010, 1'b0});
    chk("b2b.paddr2", {PADDR, PWRITE}, {8'h41, 1'b0});
    req = 0; drive_slaves(1, 0, 0, 0);
    step();
    chk("b2b.access2", {state, PENABLE, done}, {2'd2, 1'b1, 1'b0});
    drive_slaves(1, 1, 0, 32'h600DD00D);
    step();
    chk("b2b.done2", {done, err, rdata, state}, {1'b1, 1'b0, 32'h600DD00D, 2'd0});
    drive_slaves(-1, 0, 0, 0);
    step();
    chk("b2b.quiet", {done, err, rdata}, 0);

    // Back-to-back with an unmapped second command.
    req = 1; req_write = 1; req_addr = 8'h02; req_wdata = 32'h0;
    drive_slaves(0, 0, 0, 0);
    step();
    req_write = 0; req_addr = 8'hC4; drive_slaves(0, 0, 0, 0);
    step();
    drive_slaves(0, 1, 0, 0); #1;
    chk("b2bu.ready_c2", req_ready, 1);
    step();
    chk("b2bu.done1", {done, err, state, PSEL}, {1'b1, 1'b0, 2'd0, 3'b000});
    req = 0; drive_slaves(-1, 0, 0, 0);
    step();
    chk("b2bu.done2", {done, err, rdata}, {1'b1, 1'b1, 32'h0});
    step();
    chk("b2bu.quiet", {done, err}, 0);

    // Reset during the ACCESS phase of a wait-stated read.
    req = 1; req_write = 0; req_addr = 8'h80;
    drive_slaves(2, 0, 0, 0);
    step();
    req = 0; drive_slaves(2, 0, 0, 0);
    step();
    drive_slaves(2, 0, 0, 0);
    step();
    chk("rst.in_access", {state, PENABLE}, {2'd2, 1'b1});
    PRESET = 1; drive_slaves(2, 0, 0, 0);
    step();
    chk("rst.dropped", {state, PSEL, PENABLE, done}, 0);
    PRESET = 0;
    begin
      bit any_done;
      any_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
        drive_slaves(2, 1, 0, 32'h1);
        step();
        any_done = any_done | done;
      end
      chk("rst.no_done", any_done, 0);
    end
    drive_slaves(-1, 0, 0, 0);
    run_vec(tbl[1], "post_rst");

    for (int n = 0; n < 40; n++) begin
      t.wr     = 1'($urandom);
      t.addr   = 8'($urandom);
      t.wdata  = $urandom;
      t.waits  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 4));
      t.slverr = ($urandom_range(0, 3) == 0);
      t.prdata = $urandom;
      run_vec(model(t), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
